// File: rtl/operand_unpacker.sv
// Splits a packed word into ELEM_W-wide elements and emits them one per
// output handshake, element 0 first, with a zero-bubble reload on the final element.
module operand_unpacker #(
  parameter  int unsigned WORD_W = 32,
  parameter  int unsigned ELEM_W = 8,
  localparam int unsigned N      = WORD_W / ELEM_W,
  localparam int unsigned CW     = $clog2(N) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic [CW-1:0]     in_nelem_i,
  input  logic              in_last_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [ELEM_W-1:0] out_elem_o,
  output logic              out_last_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o
);

  localparam int unsigned IW = CW - 1;

  localparam logic [0:0] EMPTY  = 1'b0;
  localparam logic [0:0] UNPACK = 1'b1;

  if ((WORD_W % ELEM_W) != 0 || N < 2) begin : g_bad_params
    $error("operand_unpacker: WORD_W must be a multiple of ELEM_W with at least 2 elements");
  end

  logic [0:0]        r_state;
  logic [WORD_W-1:0] r_word;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic              r_last;

  logic [ELEM_W-1:0] w_elems [N];
  logic              w_unpack;
  logic              w_final;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [CW-1:0]     w_nelem;

  for (genvar k = 0; k < N; k++) begin : g_elems
    assign w_elems[k] = r_word[k*ELEM_W +: ELEM_W];
  end

  assign w_unpack   = (r_state == UNPACK);
  assign w_final    = ({1'b0, r_idx} == (r_cnt - CW'(1)));
  assign w_out_fire = w_unpack && out_ready_i;
  assign w_in_fire  = in_valid_i && in_ready_o;
  assign w_nelem    = (in_nelem_i == '0 || in_nelem_i > CW'(N)) ? CW'(N) : in_nelem_i;

  // Ready depends only on held state and out_ready_i, never on the input side.
  assign in_ready_o  = !w_unpack || (out_ready_i && w_final);
  assign out_valid_o = w_unpack;
  assign out_last_o  = w_unpack && w_final && r_last;
  assign busy_o      = w_unpack;
  // Word and idx are left untouched on the return to EMPTY so the output holds.
  assign out_elem_o  = w_elems[r_idx];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= EMPTY;
      r_word  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else if (w_in_fire) begin
      r_state <= UNPACK;
      r_word  <= in_data_i;
      r_cnt   <= w_nelem;
      r_idx   <= '0;
      r_last  <= in_last_i;
    end else if (w_out_fire) begin
      if (w_final) begin
        r_state <= EMPTY;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_operand_unpacker.sv
// Directed bench for operand_unpacker with hand-computed expected elements.
module tb_operand_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [2:0]  in_nelem;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_elem;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  operand_unpacker #(
    .WORD_W(32),
    .ELEM_W(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_data_i  (in_data),
    .in_nelem_i (in_nelem),
    .in_last_i  (in_last),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_elem_o (out_elem),
    .out_last_o (out_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] e, input logic l);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".elem"},  32'(out_elem),  32'(e));
    chk({tag, ".last"},  32'(out_last),  32'(l));
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] held);
    chk_out(tag, 1'b0, held, 1'b0);
    chk({tag, ".busy"},  32'(busy),     32'd0);
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
  endtask

  // Accept one word then drain four elements with out_ready held high.
  task automatic run4(input string tag, input logic [31:0] d, input logic [2:0] n,
                      input logic l, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [7:0] e3);
    in_data = d; in_nelem = n; in_last = l; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, ".acc_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out({tag, ".e0"}, 1'b1, e0, 1'b0); tick();
    chk_out({tag, ".e1"}, 1'b1, e1, 1'b0); tick();
    chk_out({tag, ".e2"}, 1'b1, e2, 1'b0); tick();
    chk_out({tag, ".e3"}, 1'b1, e3, l);    tick();
    chk_idle({tag, ".done"}, e3);
  endtask

  initial begin
    rst_n = 1'b0; in_data = 32'h1234_5678; in_nelem = 3'd4; in_last = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1; in_valid = 1'b0;
    chk_idle("reset", 8'h00);

    // Basic four-element word
    run4("basic", 32'h80FF_7F01, 3'd4, 1'b0, 8'h01, 8'h7F, 8'hFF, 8'h80);

    // Partial word flagged last
    in_data = 32'hAABB_CCDD; in_nelem = 3'd2; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_out("part.e0", 1'b1, 8'hDD, 1'b0);
    chk("part.e0_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("part.e1", 1'b1, 8'hCC, 1'b1);
    chk("part.e1_ready", 32'(in_ready), 32'd1);
    tick();
    chk_idle("part.done", 8'hCC);

    // Back-to-back: bytes count 0x00..0x0B across three words
    in_data = 32'h0302_0100; in_nelem = 3'd4; in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 32'h0706_0504;
    for (int unsigned k = 0; k < 12; k++) begin
      chk_out($sformatf("b2b.e%0d", k), 1'b1, 8'(k), 1'b0);
      chk($sformatf("b2b.ready%0d", k), 32'(in_ready), 32'((k % 4) == 3));
      if (k == 11) in_valid = 1'b0;
      tick();
      if (k == 3) in_data = 32'h0B0A_0908;
    end
    chk_idle("b2b.done", 8'h0B);

    // Backpressure at idx 1
    in_data = 32'h4433_2211; in_nelem = 3'd4; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_out("bp.e0", 1'b1, 8'h11, 1'b0);
    tick();
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      chk_out($sformatf("bp.hold%0d", k), 1'b1, 8'h22, 1'b0);
      chk($sformatf("bp.hold_ready%0d", k), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    chk_out("bp.e1", 1'b1, 8'h22, 1'b0); tick();
    chk_out("bp.e2", 1'b1, 8'h33, 1'b0); tick();
    chk_out("bp.e3", 1'b1, 8'h44, 1'b1); tick();
    chk_idle("bp.done", 8'h44);

    // Element count clamping
    run4("clamp0", 32'hDEAD_BEEF, 3'd0, 1'b1, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    run4("clamp7", 32'h1234_5678, 3'd7, 1'b0, 8'h78, 8'h56, 8'h34, 8'h12);

    // Reset after two of four elements, with a word offered during reset
    in_data = 32'hCAFE_F00D; in_nelem = 3'd4; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_out("mid.e0", 1'b1, 8'h0D, 1'b0); tick();
    chk_out("mid.e1", 1'b1, 8'hF0, 1'b0); tick();
    rst_n = 1'b0; in_data = 32'h9999_9999; in_valid = 1'b1;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    chk_idle("mid.reset", 8'h00);
    tick();
    chk_idle("mid.stay", 8'h00);
    run4("mid.new", 32'h5A4B_3C2D, 3'd4, 1'b0, 8'h2D, 8'h3C, 8'h4B, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
